// File: rtl/uart_trx_p.sv
// uart_trx_p: parametrised UART transmitter + mid-bit sampling receiver.
// Optional parity bit when UART_PARITY_EN is defined (PARITY_ODD selects sense).
// Ports: clk, reset (sync, active-high),
//   tx_valid/tx_data/tx_ready/tx : host word in, serial line out (idle high)
//   rx : async serial in; rx_data/rx_valid/rx_frame_err/rx_parity_err : results
module uart_trx_p #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err,
  output logic              rx_parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] DLAST = 4'(DATA_W - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_e;

  // ---------------- transmitter ----------------
  state_e            txs_q, txs_d;
  logic [CW-1:0]     tcnt_q, tcnt_d;
  logic [3:0]        tidx_q, tidx_d;
  logic [DATA_W-1:0] tsh_q, tsh_d;
  logic              tx_q, tx_d;
  logic              twrap;
`ifdef UART_PARITY_EN
  logic              tpar_q, tpar_d;
`endif

  assign twrap    = (tcnt_q == LAST);
  assign tx_ready = (txs_q == S_IDLE);
  assign tx       = tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      txs_q  <= S_IDLE;
      tcnt_q <= '0;
      tidx_q <= '0;
      tsh_q  <= '0;
      tx_q   <= 1'b1;
`ifdef UART_PARITY_EN
      tpar_q <= 1'b0;
`endif
    end else begin
      txs_q  <= txs_d;
      tcnt_q <= tcnt_d;
      tidx_q <= tidx_d;
      tsh_q  <= tsh_d;
      tx_q   <= tx_d;
`ifdef UART_PARITY_EN
      tpar_q <= tpar_d;
`endif
    end
  end

  // tx_q is registered one state ahead so the line changes
  // on the same edge as the state.
  always_comb begin
    txs_d  = txs_q;
    tcnt_d = twrap ? '0 : tcnt_q + 1'b1;
    tidx_d = tidx_q;
    tsh_d  = tsh_q;
    tx_d   = tx_q;
`ifdef UART_PARITY_EN
    tpar_d = tpar_q;
`endif
    unique case (txs_q)
      S_IDLE: begin
        tcnt_d = '0;
        tx_d   = 1'b1;
        if (tx_valid) begin
          tsh_d = tx_data;
`ifdef UART_PARITY_EN
          tpar_d = ^tx_data ^ 1'(PARITY_ODD);
`endif
          tx_d  = 1'b0;
          txs_d = S_START;
        end
      end
      S_START: begin
        if (twrap) begin
          txs_d  = S_DATA;
          tidx_d = '0;
          tx_d   = tsh_q[0];
        end
      end
      S_DATA: begin
        if (twrap) begin
          tsh_d = tsh_q >> 1;
          if (tidx_q == DLAST) begin
            tidx_d = '0;
`ifdef UART_PARITY_EN
            txs_d = S_PAR;
            tx_d  = tpar_q;
`else
            txs_d = S_STOP;
            tx_d  = 1'b1;
`endif
          end else begin
            tidx_d = tidx_q + 1'b1;
            tx_d   = tsh_q[1];
          end
        end
      end
      S_PAR: begin
        if (twrap) begin
          txs_d  = S_STOP;
          tidx_d = '0;
          tx_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (twrap) begin
          if (tidx_q == SLAST) begin
            txs_d = S_IDLE;
          end else begin
            tidx_d = tidx_q + 1'b1;
          end
          tx_d = 1'b1;
        end
      end
      default: txs_d = S_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  logic [1:0]        sync_q;
  logic              rx_s;
  state_e            rxs_q, rxs_d;
  logic [CW-1:0]     rcnt_q, rcnt_d;
  logic [3:0]        ridx_q, ridx_d;
  logic [DATA_W-1:0] rsh_q, rsh_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              armed_q, armed_d;
  logic              rvalid_q, rvalid_d;
  logic              rferr_q, rferr_d;
  logic              rwrap;
  logic              perr;
`ifdef UART_PARITY_EN
  logic              perr_q, perr_d;
  logic              rperr_q, rperr_d;
  assign perr          = perr_q;
  assign rx_parity_err = rperr_q;
`else
  logic              unused_cfg;
  assign unused_cfg    = 1'(PARITY_ODD);
  assign perr          = 1'b0;
  assign rx_parity_err = 1'b0;
`endif

  assign rx_s         = sync_q[1];
  assign rwrap        = (rcnt_q == LAST);
  assign rx_data      = rdata_q;
  assign rx_valid     = rvalid_q;
  assign rx_frame_err = rferr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 2'b11;
      rxs_q    <= S_IDLE;
      rcnt_q   <= '0;
      ridx_q   <= '0;
      rsh_q    <= '0;
      rdata_q  <= '0;
      armed_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q   <= 1'b0;
      rperr_q  <= 1'b0;
`endif
    end else begin
      sync_q   <= {sync_q[0], rx};
      rxs_q    <= rxs_d;
      rcnt_q   <= rcnt_d;
      ridx_q   <= ridx_d;
      rsh_q    <= rsh_d;
      rdata_q  <= rdata_d;
      armed_q  <= armed_d;
      rvalid_q <= rvalid_d;
      rferr_q  <= rferr_d;
`ifdef UART_PARITY_EN
      perr_q   <= perr_d;
      rperr_q  <= rperr_d;
`endif
    end
  end

  always_comb begin
    rxs_d    = rxs_q;
    rcnt_d   = rwrap ? '0 : rcnt_q + 1'b1;
    ridx_d   = ridx_q;
    rsh_d    = rsh_q;
    rdata_d  = rdata_q;
    armed_d  = armed_q;
    rvalid_d = 1'b0;
    rferr_d  = 1'b0;
`ifdef UART_PARITY_EN
    perr_d   = perr_q;
    rperr_d  = 1'b0;
`endif
    unique case (rxs_q)
      S_IDLE: begin
        rcnt_d  = '0;
        // a low line only starts a frame once it has been high
        armed_d = armed_q | rx_s;
        if (armed_q && !rx_s) rxs_d = S_START;
      end
      S_START: begin
        if (rcnt_q == HALF) begin
          rcnt_d = '0;
          ridx_d = '0;
          rxs_d  = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rwrap) begin
          rsh_d = {rx_s, rsh_q[DATA_W-1:1]};
          if (ridx_q == DLAST) begin
            ridx_d = '0;
`ifdef UART_PARITY_EN
            rxs_d = S_PAR;
`else
            rxs_d = S_STOP;
`endif
          end else begin
            ridx_d = ridx_q + 1'b1;
          end
        end
      end
      S_PAR: begin
`ifdef UART_PARITY_EN
        if (rwrap) begin
          perr_d = rx_s ^ (^rsh_q) ^ 1'(PARITY_ODD);
          rxs_d  = S_STOP;
        end
`else
        rxs_d = S_IDLE;
`endif
      end
      S_STOP: begin
        if (rwrap) begin
          rxs_d   = S_IDLE;
          armed_d = rx_s;
          rferr_d = !rx_s;
`ifdef UART_PARITY_EN
          rperr_d = perr_q;
`endif
          if (rx_s && !perr) begin
            rvalid_d = 1'b1;
            rdata_d  = rsh_q;
          end
        end
      end
      default: rxs_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_trx_p.sv
// tb_uart_trx_p: self-checking bench for uart_trx_p (loopback + driven rx).
// Build with or without UART_PARITY_EN.
module tb_uart_trx_p;
  localparam int DW = 8;
  localparam int CPB = 4;
  localparam int SB = 1;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 1 + DW + P + SB;
  localparam int F = NB * CPB;
  localparam int GCPB = 16;
  localparam int SI = 1 + DW + P;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic tx_ready, tx;
  logic loop = 1'b1;
  logic rx_drv = 1'b1;
  logic rx;
  logic [DW-1:0] rx_data;
  logic rx_valid, rx_frame_err, rx_parity_err;

  logic g_tx_valid = 1'b0;
  logic [DW-1:0] g_tx_data = '0;
  logic g_tx_ready, g_tx;
  logic g_rx = 1'b1;
  logic [DW-1:0] g_rx_data;
  logic g_rx_valid, g_rx_frame_err, g_rx_parity_err;

  assign rx = loop ? tx : rx_drv;

  uart_trx_p #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB),
    .STOP_BITS(SB), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx(tx), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );

  uart_trx_p #(
    .DATA_W(DW), .CLKS_PER_BIT(GCPB),
    .STOP_BITS(1), .PARITY_ODD(0)
  ) gdut (
    .clk(clk), .reset(reset),
    .tx_valid(g_tx_valid), .tx_data(g_tx_data),
    .tx_ready(g_tx_ready), .tx(g_tx), .rx(g_rx),
    .rx_data(g_rx_data), .rx_valid(g_rx_valid),
    .rx_frame_err(g_rx_frame_err),
    .rx_parity_err(g_rx_parity_err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected line levels of one frame, index = bit slot
  function automatic logic [15:0] mkframe(input logic [DW-1:0] d);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    f[DW:1] = d;
`ifdef UART_PARITY_EN
    f[DW+1] = ^d;
`endif
    return f;
  endfunction

  // receive-side recorders
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] g_got[$];
  int nferr = 0, nperr = 0, g_pulses = 0, dbl = 0;
  logic pv = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (rx_frame_err) nferr++;
    if (rx_parity_err) nperr++;
    if (rx_valid && pv) dbl++;
    pv = rx_valid;
    if (g_rx_valid) g_got.push_back(g_rx_data);
    if (g_rx_frame_err || g_rx_parity_err) g_pulses++;
  end

  // transmit-line model: after an accept, F busy cycles
  // carrying the frame slots, then an idle ready cycle
  bit txmon = 1'b0;
  int tpos = -1;
  int cyc = 0;
  int acc_q[$];
  logic [15:0] tframe = '1;

  always @(negedge clk) begin
    cyc++;
    if (!txmon || reset) begin
      tpos = -1;
    end else begin
      if (tpos >= F) tpos = -1;
      if (tpos >= 0) begin
        chk("tx_bit", tx, tframe[tpos/CPB]);
        chk("tx_busy", tx_ready, 0);
        tpos++;
      end else begin
        chk("tx_idle", tx, 1);
        chk("tx_rdy", tx_ready, 1);
        if (tx_valid) begin
          tframe = mkframe(tx_data);
          tpos = 0;
          acc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic send_tx(input logic [DW-1:0] d, output int low);
    int b;
    b = 0;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data = d;
    @(negedge clk);
    while (!tx_ready && b < 4*F) begin
      b++;
      @(negedge clk);
    end
    chk("tx_rdy_to", 32'(b < 4*F), 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    low = 0;
    @(negedge clk);
    while (!tx_ready && low < 4*F) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic [15:0] f, input int nb,
                       input int cpb, input bit g);
    for (int i = 0; i < nb; i++) begin
      repeat (cpb) begin
        @(posedge clk); #1;
        if (g) g_rx = f[i];
        else rx_drv = f[i];
      end
    end
  endtask

  task automatic hold_rx(input logic v, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_drv = v;
    end
  endtask

  task automatic drain(input string tag);
    int b;
    b = 0;
    while (got_q.size() < exp_q.size() && b < 8*F) begin
      @(negedge clk);
      b++;
    end
    repeat (3*CPB) @(negedge clk);
    chk({tag, "_cnt"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int ferr_exp;
    int perr_exp;
    logic [DW-1:0] w;
    logic [DW-1:0] bb[3];
    logic [15:0] f;
    bit bad;
    ferr_exp = 0;
    perr_exp = 0;
    bb[0] = 8'h00;
    bb[1] = 8'hFF;
    bb[2] = 8'h3C;

    // power-on reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_rdy", tx_ready, 1);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", rx_frame_err, 0);
    chk("rst_perr", rx_parity_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // reset 3 cycles, starting at cycle 10 of a frame
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data = 8'h5A;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", tx_ready, 0);
    reset = 1'b1;
    got_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_tx", tx, 1);
    chk("mrst_rdy", tx_ready, 1);
    chk("mrst_data", rx_data, 0);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_ferr", rx_frame_err, 0);
    chk("mrst_perr", rx_parity_err, 0);
    repeat (2*F) @(negedge clk);
    chk("mrst_norx", got_q.size(), 0);
    chk("mrst_noerr", nferr + nperr, 0);
    @(posedge clk); #1;
    txmon = 1'b1;

    // loopback single word
    send_tx(8'hA5, low);
    chk("a5_rdy_low", low, F);
    exp_q.push_back(8'hA5);
    drain("a5");

    // back-to-back with tx_valid held
    acc_q.delete();
    @(posedge clk); #1;
    tx_data = bb[0];
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int b;
      b = 0;
      @(negedge clk);
      while (!tx_ready && b < 4*F) begin
        b++;
        @(negedge clk);
      end
      @(posedge clk); #1;
      if (i < 2) tx_data = bb[i+1];
      else tx_valid = 1'b0;
      exp_q.push_back(bb[i]);
    end
    chk("b2b_acc", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("b2b_gap1", acc_q[1] - acc_q[0], F + 1);
      chk("b2b_gap2", acc_q[2] - acc_q[1], F + 1);
    end
    drain("b2b");
    chk("b2b_err", nferr + nperr, 0);

    // framing error on driven line, 0x55, line held low
    loop = 1'b0;
    f = mkframe(8'h55);
    f[SI] = 1'b0;
    drive(f, SI + 1, CPB, 1'b0);
    hold_rx(1'b0, 20);
    hold_rx(1'b1, 3*CPB);
    ferr_exp++;
    chk("fe_cnt", nferr, ferr_exp);
    chk("fe_hold", rx_data, 8'h3C);
    drain("fe");

    // random driven frames, some with a bad stop bit
    for (int k = 0; k < 10; k++) begin
      w = DW'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      f = mkframe(w);
      if (bad) f[SI] = 1'b0;
      drive(f, SI + 1, CPB, 1'b0);
      if (bad) begin
        hold_rx(1'b0, 8);
        hold_rx(1'b1, 2*CPB);
        ferr_exp++;
      end else begin
        exp_q.push_back(w);
      end
      hold_rx(1'b1, $urandom_range(0, 3));
    end
    drain("rrx");
    chk("rrx_ferr", nferr, ferr_exp);

    // random loopback words
    loop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w = DW'($urandom);
      send_tx(w, low);
      chk("rtx_rdy_low", low, F);
      exp_q.push_back(w);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    drain("rtx");

    // glitch reject on the slow instance
    @(posedge clk); #1;
    g_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    g_rx = 1'b1;
    repeat (4*GCPB) @(posedge clk);
    chk("gl_pulse", g_pulses, 0);
    chk("gl_norx", g_got.size(), 0);
    f = mkframe(8'hC3);
    drive(f, 1 + DW + 1, GCPB, 1'b1);
    repeat (3*GCPB) @(posedge clk);
    chk("gl_cnt", g_got.size(), 1);
    if (g_got.size() > 0) chk("gl_data", g_got[0], 8'hC3);

`ifdef UART_PARITY_EN
    send_tx(8'h07, low);
    chk("par_rdy_low", low, F);
    exp_q.push_back(8'h07);
    drain("par");
    loop = 1'b0;
    f = mkframe(8'h3A);
    f[DW+1] = ~f[DW+1];
    drive(f, NB, CPB, 1'b0);
    hold_rx(1'b1, 3*CPB);
    perr_exp++;
    chk("pe_cnt", nperr, perr_exp);
    drain("pe");
    f = mkframe(8'h91);
    f[DW+1] = ~f[DW+1];
    f[SI] = 1'b0;
    drive(f, NB, CPB, 1'b0);
    hold_rx(1'b0, 8);
    hold_rx(1'b1, 3*CPB);
    perr_exp++;
    ferr_exp++;
    chk("pfe_perr", nperr, perr_exp);
    chk("pfe_ferr", nferr, ferr_exp);
    drain("pfe");
`endif

    chk("pulse_width", dbl, 0);
    chk("perr_total", nperr, perr_exp);
    chk("ferr_total", nferr, ferr_exp);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_trx_p.md
# uart_trx_p

Parametrised UART transceiver: one transmitter and one receiver sharing one clock, with a configurable bit period, data width and stop-bit count. The receiver samples each bit at its midpoint and flags framing and (optionally) parity errors. It is the next-generation replacement for the fixed one-clock-per-bit 8N1 transmitter/receiver pair. It sits between the host byte interface and the serial pins, and is usable in loopback (`tx` tied to `rx`).

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..9.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, legal ≥4.
- `STOP_BITS`, 1: TX stop bits, legal 1 or 2. RX checks one stop bit only.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Only used when `UART_PARITY_EN` is defined.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: reset is synchronous and active-high.
- `tx_valid` in 1: host has a word to send.
- `tx_data` in DATA_W: word to send, sent LSB first.
- `tx_ready` out 1: transmitter can accept a word.
- `tx` out 1: serial output, idles high.
- `rx` in 1: serial input, asynchronous.
- `rx_data` out DATA_W: last good received word.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `rx_frame_err` out 1: one-cycle pulse when the stop bit samples 0.
- `rx_parity_err` out 1: one-cycle pulse on parity mismatch. Tied 0 without `UART_PARITY_EN`.

## Operation
- Reset values:
  - `tx`=1, `tx_ready`=1.
  - `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_parity_err`=0.
  - Both FSMs go to IDLE; counters go to 0; RX synchroniser flops go to 1.
  - Reset mid-frame aborts immediately. No partial word is reported.
- Per-FSM bit counter counts 0..CLKS_PER_BIT-1 and wraps. Bit index counts 0..DATA_W-1.
- TX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - Accept is `tx_valid && tx_ready` in IDLE. On accept, latch `tx_data`, deassert `tx_ready` next cycle, enter START.
  - START drives `tx`=0 for CLKS_PER_BIT cycles.
  - DATA drives `tx_data[i]` for CLKS_PER_BIT cycles per bit, i = 0..DATA_W-1.
  - PARITY drives the XOR of the data bits, XOR `PARITY_ODD`.
  - STOP drives `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - `tx_valid` while busy is ignored; `tx_data` is don't-care after accept.
- RX path: `rx` passes through a 2-flop synchroniser, giving `rx_s`.
- RX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: armed only after `rx_s` has been seen 1. When armed, `rx_s`=0 enters START with the counter cleared.
  - START: at count CLKS_PER_BIT/2−1 (integer division), recheck `rx_s`. If 0, go to DATA with the counter cleared. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: sample `rx_s` at each counter wrap (mid-bit) into bit i, LSB first.
  - PARITY: sample one bit and compare against the computed parity.
  - STOP: at the mid-bit sample, act on the stop bit:
    - Stop bit = 1 and no parity error: update `rx_data` and pulse `rx_valid`.
    - Stop bit = 0: pulse `rx_frame_err`; `rx_data` is unchanged; IDLE disarms until `rx_s`=1 (break handling).
    - Parity error: pulse `rx_parity_err`; `rx_data` is unchanged; no `rx_valid`.
    - Parity error and framing error together: pulse both error outputs.
  - The FSM returns to IDLE the cycle after the stop sample, so the next start bit is detected inside the stop period.
- TX and RX are fully independent. Simultaneous TX accept and RX completion are both honoured in the same cycle.

## Timing
- TX frame length F = (1 + DATA_W + P + STOP_BITS) × CLKS_PER_BIT cycles. P = 1 with `UART_PARITY_EN`, else 0.
- TX sequence:
  - Accept at edge N. `tx` falls at edge N+1.
  - `tx_ready` is 0 from N+1 through N+F and returns to 1 at N+F+1.
  - Back-to-back accept is possible at N+F+1, giving a continuous stream of one frame every F+1 cycles.
- RX latency:
  - Edge E: `rx` falls, first seen by the synchroniser.
  - E+2: START is entered (2-cycle synchroniser).
  - Data bit i is sampled at E+2+CLKS_PER_BIT/2+(i+1)×CLKS_PER_BIT.
  - `rx_valid` (or an error pulse) goes high one cycle after the stop sample, for exactly 1 cycle.
- Error pulses and `rx_valid` are registered outputs with no combinational path from `rx`.

## Configuration
- `UART_PARITY_EN` defined:
  - TX inserts one parity bit after the data bits.
  - RX samples and checks it, driving `rx_parity_err`.
  - `PARITY_ODD` selects the sense.
- `UART_PARITY_EN` undefined:
  - No PARITY states; P = 0.
  - `rx_parity_err` is constant 0.
  - `PARITY_ODD` is ignored.

## Test plan
- Reset: hold `reset` 3 cycles mid-TX-frame (cycle 10 of 40) → next cycle `tx`=1, `tx_ready`=1, all RX outputs 0; no `rx_valid` follows.
- Loopback 8N1: DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1, no parity, send 0xA5 → `tx_ready` low 40 cycles; one `rx_valid` pulse with `rx_data`=0xA5; no errors.
- Back-to-back: send 0x00, 0xFF, 0x3C with `tx_valid` held high → accepts 41 cycles apart; three `rx_valid` pulses with `rx_data` 0x00, 0xFF, 0x3C in order.
- Framing error: drive the `rx` frame for 0x55 with the stop bit = 0 and the line held low 20 cycles → one `rx_frame_err` pulse; `rx_data` keeps its prior value; no new frame until `rx` returns high.
- Glitch reject: CLKS_PER_BIT=16, `rx` low for 3 cycles then high → no state exit from IDLE after the recheck; no output pulses.
- Parity (with `UART_PARITY_EN`, PARITY_ODD=0): send 0x07 → TX parity bit 1, frame 44 cycles at CLKS_PER_BIT=4. Injecting a flipped parity bit → one `rx_parity_err` pulse, no `rx_valid`.
